// File: rtl/fp_pkg.sv
// Shared field widths, constants and operand unpacking for the single-precision adder.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SUM_W = 28;
  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
  localparam logic [EXP_W-1:0] EXP_MAX  = 8'd255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_UFLUSH   = 0;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant24;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } fp_unpacked_t;

  // With ftz clear a denormal is kept as 0.man * 2^(1-bias), i.e. exponent field 1 with no hidden bit.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] v, input logic ftz);
    fp_unpacked_t     u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] man;
    e         = v[30:23];
    man       = v[22:0];
    u.sign    = v[31];
    u.is_nan  = (e == EXP_MAX) && (man != '0);
    u.is_inf  = (e == EXP_MAX) && (man == '0);
    u.is_zero = (e == '0) && (ftz || (man == '0));
    u.exp     = u.is_zero ? '0 : ((e == '0) ? 8'd1 : e);
    u.mant24  = u.is_zero ? '0 : {(e != '0), man};
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the adder's 28-bit sum; an all-zero input reports 28.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [SUM_W-1:0] val_i,
  output logic [4:0]       lzc_o
);

  always_comb begin
    lzc_o = 5'd28;
    for (int i = 0; i < SUM_W; i++) begin
      if (val_i[i]) lzc_o = 5'(SUM_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Pipelined IEEE 754 single-precision adder: operand capture, align, add, normalise/round/pack.
// Handshake: a beat moves on a rising edge when valid && ready; adv = !out_valid || out_ready shifts every rank at once.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter logic [31:0] QNAN_VALUE = QNAN,
  parameter int          FTZ        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_a,
  input  logic [31:0] fp_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_sum,
  output logic [2:0]  fp_flags
);

  logic adv;

  logic        op_v_q;
  logic [31:0] op_a_q, op_b_q;

  logic        al_v_q, al_sign_q, al_sub_q, al_spec_q, al_inv_q;
  logic [7:0]  al_exp_q;
  logic [26:0] al_xm_q, al_ym_q;
  logic [31:0] al_spec_val_q;

  logic        ad_v_q, ad_sign_q, ad_spec_q, ad_inv_q;
  logic [7:0]  ad_exp_q;
  logic [27:0] ad_sum_q;
  logic [4:0]  ad_lzc_q;
  logic [31:0] ad_spec_val_q;

  logic        out_v_q;
  logic [31:0] out_sum_q;
  logic [2:0]  out_flags_q;

  assign adv       = !out_v_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_v_q;
  assign fp_sum    = out_sum_q;
  assign fp_flags  = out_flags_q;

  always_ff @(posedge clk) begin
    if (rst) op_v_q <= 1'b0;
    else if (adv) op_v_q <= in_valid;
    if (adv) begin
      op_a_q <= fp_a;
      op_b_q <= fp_b;
    end
  end

  fp_unpacked_t ua, ub;
  logic        x_sign, y_sign;
  logic [7:0]  x_exp, y_exp, d;
  logic [23:0] x_mant, y_mant;
  logic [26:0] y_ext, y_sh, y_lost, al_ym_d;
  logic        al_spec_d, al_inv_d;
  logic [31:0] al_spec_val_d;

  always_comb begin
    ua = fp_unpack(op_a_q, FTZ != 0);
    ub = fp_unpack(op_b_q, FTZ != 0);
    // X is always the larger magnitude so the subtract below never goes negative.
    if ({ub.exp, ub.mant24} > {ua.exp, ua.mant24}) begin
      x_sign = ub.sign; x_exp = ub.exp; x_mant = ub.mant24;
      y_sign = ua.sign; y_exp = ua.exp; y_mant = ua.mant24;
    end else begin
      x_sign = ua.sign; x_exp = ua.exp; x_mant = ua.mant24;
      y_sign = ub.sign; y_exp = ub.exp; y_mant = ub.mant24;
    end
    d      = x_exp - y_exp;
    y_ext  = {y_mant, 3'b000};
    y_sh   = y_ext >> d[4:0];
    y_lost = y_ext & ~({27{1'b1}} << d[4:0]);
    if (d >= 8'd27) al_ym_d = {26'd0, |y_mant};
    else            al_ym_d = {y_sh[26:1], y_sh[0] | (|y_lost)};

    al_spec_d     = 1'b1;
    al_inv_d      = 1'b0;
    al_spec_val_d = '0;
    if (ua.is_nan || ub.is_nan) begin
      al_spec_val_d = QNAN_VALUE;
    end else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
      al_spec_val_d = QNAN_VALUE;
      al_inv_d      = 1'b1;
    end else if (ua.is_inf) begin
      al_spec_val_d = {ua.sign, EXP_MAX, 23'd0};
    end else if (ub.is_inf) begin
      al_spec_val_d = {ub.sign, EXP_MAX, 23'd0};
    end else if (ua.is_zero && ub.is_zero) begin
      al_spec_val_d = {ua.sign & ub.sign, 31'd0};
    end else if (ub.is_zero) begin
      al_spec_val_d = op_a_q;
    end else if (ua.is_zero) begin
      al_spec_val_d = op_b_q;
    end else begin
      al_spec_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) al_v_q <= 1'b0;
    else if (adv) al_v_q <= op_v_q;
    if (adv) begin
      al_sign_q     <= x_sign;
      al_sub_q      <= x_sign ^ y_sign;
      al_exp_q      <= x_exp;
      al_xm_q       <= {x_mant, 3'b000};
      al_ym_q       <= al_ym_d;
      al_spec_q     <= al_spec_d;
      al_inv_q      <= al_inv_d;
      al_spec_val_q <= al_spec_val_d;
    end
  end

  logic [27:0] ad_sum_d;
  logic [4:0]  ad_lzc_d;

  always_comb begin
    if (al_sub_q) ad_sum_d = {1'b0, al_xm_q} - {1'b0, al_ym_q};
    else          ad_sum_d = {1'b0, al_xm_q} + {1'b0, al_ym_q};
  end

  fp_lzc u_lzc (
    .val_i (ad_sum_d),
    .lzc_o (ad_lzc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) ad_v_q <= 1'b0;
    else if (adv) ad_v_q <= al_v_q;
    if (adv) begin
      ad_sum_q      <= ad_sum_d;
      ad_lzc_q      <= ad_lzc_d;
      ad_sign_q     <= al_sign_q;
      ad_exp_q      <= al_exp_q;
      ad_spec_q     <= al_spec_q;
      ad_inv_q      <= al_inv_q;
      ad_spec_val_q <= al_spec_val_q;
    end
  end

  logic [4:0]         sh;
  logic [26:0]        norm;
  logic signed [9:0]  exp_n, exp_r;
  logic               rnd_up;
  logic [24:0]        man_r;
  logic [22:0]        frac;
  logic [31:0]        out_sum_d;
  logic [2:0]         out_flags_d;

  always_comb begin
    sh = ad_lzc_q - 5'd1;
    if (ad_sum_q[27]) begin
      norm  = {ad_sum_q[27:2], ad_sum_q[1] | ad_sum_q[0]};
      exp_n = $signed({2'b00, ad_exp_q}) + 10'sd1;
    end else begin
      norm  = ad_sum_q[26:0] << sh;
      exp_n = $signed({2'b00, ad_exp_q}) - $signed({5'b00000, sh});
    end
    // Round to nearest even on guard/round/sticky; a mantissa carry-out bumps the exponent.
    rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    man_r  = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    exp_r  = exp_n + (man_r[24] ? 10'sd1 : 10'sd0);
    frac   = man_r[24] ? man_r[23:1] : man_r[22:0];

    out_sum_d   = {ad_sign_q, exp_r[7:0], frac};
    out_flags_d = '0;
    if (ad_spec_q) begin
      out_sum_d                 = ad_spec_val_q;
      out_flags_d[FLAG_INVALID] = ad_inv_q;
    end else if (ad_sum_q == '0) begin
      out_sum_d = '0;
    end else if (exp_r >= 10'sd255) begin
      out_sum_d                  = {ad_sign_q, EXP_MAX, 23'd0};
      out_flags_d[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      out_sum_d                = {ad_sign_q, 31'd0};
      out_flags_d[FLAG_UFLUSH] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q     <= 1'b0;
      out_sum_q   <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      out_v_q <= ad_v_q;
      if (ad_v_q) begin
        out_sum_q   <= out_sum_d;
        out_flags_q <= out_flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed and random checks of fp_add_pipe against hand-derived IEEE results and an integer model.
module tb_fp_add_pipe;

  localparam int EW = 68;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] fp_a, fp_b, fp_sum;
  logic [2:0]  fp_flags;

  // Entry layout: {latency_check, accept_edge[31:0], flags[2:0], sum[31:0]}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit stream_done;

  fp_add_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_a      (fp_a),
    .fp_b      (fp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_sum    (fp_sum),
    .fp_flags  (fp_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] mag, m;
    int p;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    m = mag << (23 - p);
    return {(v < 0), 8'(127 + p), m[22:0]};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] es, input logic [2:0] ef, input logic lat);
    int  n = 0;
    bit  done = 0;
    fp_a = a;
    fp_b = b;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({lat, 32'(cyc + 1), ef, es});
        done = 1;
      end else if (++n > 200) begin
        check("accept_in_time", 32'(in_ready), 32'd1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && out_valid) begin
      if (!out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        if (exp_q.size() != 0) check("stall_sum_held", fp_sum, exp_q[0][31:0]);
      end else begin
        check("have_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("fp_sum", fp_sum, e[31:0]);
          check("fp_flags", 32'(fp_flags), 32'(e[34:32]));
          if (e[67]) check("latency", 32'(cyc - int'(e[66:35])), 32'd3);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; fp_a = '0; fp_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fp_sum", fp_sum, 32'd0);
    check("rst_fp_flags", 32'(fp_flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Basic add, cancellation and signed zeros
    send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 1'b1);
    drain();
    send(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3'b000, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'b000, 1'b1);
    drain();

    // Rounding: tie-to-even, round up, below half
    send(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 3'b000, 1'b1);
    send(32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001, 3'b000, 1'b1);
    send(32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 3'b000, 1'b1);
    drain();

    // Specials, overflow, underflow flush, denormal operand
    send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3'b010, 1'b1);
    send(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b100, 1'b1);
    send(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b000, 1'b1);
    send(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 3'b000, 1'b1);
    send(32'h4040_0000, 32'h0000_0001, 32'h4040_0000, 3'b000, 1'b1);
    send(32'h0080_0000, 32'h8080_0001, 32'h8000_0000, 3'b001, 1'b1);
    drain();

    // Backpressure: six back-to-back pairs, out_ready low for cycles 4-7
    fork
      begin
        send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 1'b0);
        send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000, 1'b0);
        send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 1'b0);
        send(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 3'b000, 1'b0);
        send(32'h4080_0000, 32'hBF80_0000, 32'h4040_0000, 3'b000, 1'b0);
        send(32'hBFC0_0000, 32'h3F00_0000, 32'hBF80_0000, 3'b000, 1'b0);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 4 && c <= 7);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight
    send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 1'b0);
    send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_out", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000, 1'b1);
    drain();

    // Random integer-valued operands with random gaps and backpressure
    stream_done = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          int a, b;
          a = int'($urandom_range(2000, 0)) - 1000;
          b = int'($urandom_range(2000, 0)) - 1000;
          send(int_to_fp(a), int_to_fp(b), int_to_fp(a + b), 3'b000, 1'b0);
          repeat ($urandom_range(2, 0)) begin
            @(posedge clk);
            #1;
          end
        end
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          out_ready = ($urandom_range(3, 0) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
